// File: rtl/bus_sequencer_pkg.sv
// Shared definitions for the register-bus sequencer: opcodes, FSM states
// and default bus geometry.
package bus_sequencer_pkg;

    localparam int unsigned NREG_DEF  = 4;
    localparam int unsigned WIDTH_DEF = 16;
    localparam int unsigned IDXW_DEF  = 2;

    typedef enum logic [1:0] {
        OP_MOV  = 2'd0,
        OP_LDI  = 2'd1,
        OP_OUT  = 2'd2,
        OP_SWAP = 2'd3
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_X1,
        ST_X2,
        ST_X3,
        ST_DONE
    } state_e;

endpackage

// File: rtl/bus_sequencer_if.sv
// Command/strobe interface of the register-bus sequencer. The sequencer
// uses the master view; whoever issues commands and hosts the registers
// uses the slave view.
interface bus_sequencer_if
    import bus_sequencer_pkg::*;
#(
    parameter int unsigned NREG  = NREG_DEF,
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned IDXW  = IDXW_DEF
);
    logic              start;
    logic [1:0]        op;
    logic [IDXW-1:0]   src;
    logic [IDXW-1:0]   dst;
    logic [WIDTH-1:0]  imm;
    logic [NREG-1:0]   read;
    logic [NREG-1:0]   write;
    logic [WIDTH-1:0]  data_out;
    logic              busy;
    logic              done;

    modport master (
        input  start, op, src, dst, imm,
        output read, write, data_out, busy, done
    );

    modport slave (
        output start, op, src, dst, imm,
        input  read, write, data_out, busy, done
    );
endinterface

// File: rtl/bus_sequencer_reg_select_decoder.sv
// Index-to-one-hot strobe decoder; all zeros when disabled.
module reg_select_decoder #(
    parameter int unsigned NREG = 4,
    parameter int unsigned IDXW = 2
) (
    input  logic [IDXW-1:0] idx,
    input  logic            en,
    output logic [NREG-1:0] onehot
);

    // One bit set at idx when enabled
    always_comb begin
        onehot = '0;
        if (en) onehot[idx] = 1'b1;
    end

endmodule

// File: rtl/bus_sequencer.sv
// Register-bus master: sequences one-hot read/write strobes to carry out
// MOV, LDI, OUT and SWAP transfers between bus registers.
module bus_sequencer
    import bus_sequencer_pkg::*;
#(
    parameter int unsigned NREG  = NREG_DEF,
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned IDXW  = IDXW_DEF
) (
    input  logic              clk,
    input  logic              reset,
    bus_sequencer_if.master   cmd,
    inout  wire [WIDTH-1:0]   bus
);

    state_e            state_q, state_d;
    op_e               op_q, op_d;
    logic [IDXW-1:0]   src_q, src_d, dst_q, dst_d;
    logic [WIDTH-1:0]  imm_q, imm_d, tmp_q, tmp_d, data_out_q, data_out_d;
    logic              busy_q, busy_d, done_q, done_d, drive_en_q, drive_en_d;
    logic [NREG-1:0]   read_q, read_d, write_q, write_d;
    logic              rd_en, wr_en;
    logic [IDXW-1:0]   rd_idx, wr_idx;
    logic [WIDTH-1:0]  drive_data;

    // Next state, command latch and bus captures
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        src_d      = src_q;
        dst_d      = dst_q;
        imm_d      = imm_q;
        tmp_d      = tmp_q;
        data_out_d = data_out_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (cmd.start) begin
                    state_d = ST_X1;
                    op_d    = op_e'(cmd.op);
                    src_d   = cmd.src;
                    dst_d   = cmd.dst;
                    imm_d   = cmd.imm;
                end
            end
            ST_X1: begin
                state_d = (op_q == OP_SWAP) ? ST_X2 : ST_DONE;
                if (op_q == OP_SWAP) tmp_d = bus;
                if (op_q == OP_OUT)  data_out_d = bus;
            end
            ST_X2:   state_d = ST_X3;
            ST_X3:   state_d = ST_DONE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Strobes are decoded from the state being entered and the command as it
    // will be latched, then registered, so outputs come straight from flops
    always_comb begin
        rd_en      = 1'b0;
        wr_en      = 1'b0;
        rd_idx     = src_d;
        wr_idx     = dst_d;
        drive_en_d = 1'b0;
        case (state_d)
            ST_X1: begin
                case (op_d)
                    OP_MOV:  begin rd_en = 1'b1; wr_en = 1'b1; end
                    OP_LDI:  begin wr_en = 1'b1; drive_en_d = 1'b1; end
                    OP_OUT:  rd_en = 1'b1;
                    OP_SWAP: rd_en = 1'b1;
                    default: ;
                endcase
            end
            ST_X2: begin
                rd_en  = 1'b1;
                rd_idx = dst_d;
                wr_en  = 1'b1;
                wr_idx = src_d;
            end
            ST_X3: begin
                wr_en      = 1'b1;
                drive_en_d = 1'b1;
            end
            default: ;
        endcase
        busy_d = (state_d == ST_X1) || (state_d == ST_X2) || (state_d == ST_X3);
        done_d = (state_d == ST_DONE);
    end

    reg_select_decoder #(.NREG(NREG), .IDXW(IDXW)) u_read_dec (
        .idx    (rd_idx),
        .en     (rd_en),
        .onehot (read_d)
    );

    reg_select_decoder #(.NREG(NREG), .IDXW(IDXW)) u_write_dec (
        .idx    (wr_idx),
        .en     (wr_en),
        .onehot (write_d)
    );

    // State and output registers, cleared asynchronously
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            op_q       <= OP_MOV;
            src_q      <= '0;
            dst_q      <= '0;
            imm_q      <= '0;
            tmp_q      <= '0;
            data_out_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            drive_en_q <= 1'b0;
            read_q     <= '0;
            write_q    <= '0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            src_q      <= src_d;
            dst_q      <= dst_d;
            imm_q      <= imm_d;
            tmp_q      <= tmp_d;
            data_out_q <= data_out_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            drive_en_q <= drive_en_d;
            read_q     <= read_d;
            write_q    <= write_d;
        end
    end

    assign drive_data = (state_q == ST_X3) ? tmp_q : imm_q;
    assign bus        = drive_en_q ? drive_data : 'z;

    assign cmd.read     = read_q;
    assign cmd.write    = write_q;
    assign cmd.data_out = data_out_q;
    assign cmd.busy     = busy_q;
    assign cmd.done     = done_q;

endmodule
